multi_channel_watchdog: RTL

Parametrised, multi-channel successor to the single-heartbeat watchdog. Monitors NUM_CH independent heartbeat sources, each with its own timeout counter, revive (channel reset) pulse and consecutive-expiry strike counter. Repeated failures escalate to a latched fault and a system-level reset. Sits between the host-side heartbeat/control registers and the reset inputs of the supervised cores.

---
 rtl/multi_channel_watchdog_if.sv | 22 ++
 rtl/multi_channel_watchdog.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multi_channel_watchdog_if.sv
// rtl/multi_channel_watchdog_if.sv - host-side heartbeat/control and reset outputs of the multi-channel watchdog
interface multi_channel_watchdog_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] i_enable;
  logic [NUM_CH-1:0] i_kick;
  logic              i_fault_clear;
  logic [NUM_CH-1:0] o_ch_reset;
  logic [NUM_CH-1:0] o_expire;
  logic [NUM_CH-1:0] o_fault;
  logic              o_sys_reset;

  modport master (
    output i_enable, i_kick, i_fault_clear,
    input  o_ch_reset, o_expire, o_fault, o_sys_reset
  );

  modport slave (
    input  i_enable, i_kick, i_fault_clear,
    output o_ch_reset, o_expire, o_fault, o_sys_reset
  );
endinterface

// File: rtl/multi_channel_watchdog.sv
// rtl/multi_channel_watchdog.sv - per-channel heartbeat watchdog; WDT_ESCALATION_EN adds strikes, FAULT and o_sys_reset
module multi_channel_watchdog #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 50_000_000,
  parameter int RESET_CYCLES = 10000,
  parameter int MAX_STRIKES  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  multi_channel_watchdog_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REVIVE = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // Shared counter: timeout progress in ARMED, revive pulse width in REVIVE.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RV_LAST = CNT_W'(RESET_CYCLES - 1);

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
  logic [NUM_CH-1:0] expire_q, expire_d;

`ifdef WDT_ESCALATION_EN
  localparam int             STR_W   = (MAX_STRIKES < 2) ? 1 : $clog2(MAX_STRIKES + 1);
  localparam logic [STR_W-1:0] STR_MAX = STR_W'(MAX_STRIKES);

  logic [STR_W-1:0]  strikes_q [NUM_CH];
  logic [STR_W-1:0]  strikes_d [NUM_CH];
  logic [NUM_CH-1:0] fault_q, fault_d;
  logic              sys_reset_q, sys_reset_d;
`endif

  // Next-state, counter and output computation for every channel independently.
  always_comb begin
    ch_reset_d = '0;
    expire_d   = '0;
`ifdef WDT_ESCALATION_EN
    fault_d     = '0;
    sys_reset_d = |fault_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
`ifdef WDT_ESCALATION_EN
      strikes_d[c] = strikes_q[c];
`endif
      if (!bus.i_enable[c]) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
`ifdef WDT_ESCALATION_EN
        strikes_d[c] = '0;
`endif
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            state_d[c] = ST_ARMED;
            cnt_d[c]   = '0;
          end
          ST_ARMED: begin
`ifdef WDT_ESCALATION_EN
            if (bus.i_fault_clear) strikes_d[c] = '0;
`endif
            if (bus.i_kick[c]) begin
              cnt_d[c] = '0;
`ifdef WDT_ESCALATION_EN
              strikes_d[c] = '0;
`endif
            end else if (cnt_q[c] == TO_LAST) begin
              expire_d[c] = 1'b1;
              cnt_d[c]    = '0;
`ifdef WDT_ESCALATION_EN
              // Strikes never exceed MAX-1 while ARMED, so this is the saturating step.
              if (strikes_d[c] >= STR_MAX - STR_W'(1)) begin
                strikes_d[c] = STR_MAX;
                state_d[c]   = ST_FAULT;
              end else begin
                strikes_d[c] = strikes_d[c] + STR_W'(1);
                state_d[c]   = ST_REVIVE;
              end
`else
              state_d[c] = ST_REVIVE;
`endif
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end
          ST_REVIVE: begin
`ifdef WDT_ESCALATION_EN
            if (bus.i_fault_clear) strikes_d[c] = '0;
`endif
            if (cnt_q[c] == RV_LAST) begin
              state_d[c] = ST_ARMED;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end
          ST_FAULT: begin
`ifdef WDT_ESCALATION_EN
            if (bus.i_fault_clear) begin
              state_d[c]   = ST_IDLE;
              cnt_d[c]     = '0;
              strikes_d[c] = '0;
            end
`else
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
`endif
          end
          default: begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
          end
        endcase
      end
      ch_reset_d[c] = (state_d[c] == ST_REVIVE) || (state_d[c] == ST_FAULT);
`ifdef WDT_ESCALATION_EN
      fault_d[c] = (state_d[c] == ST_FAULT);
`endif
    end
  end

  // State, counters and registered outputs; rst clears everything on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
`ifdef WDT_ESCALATION_EN
        strikes_q[c] <= '0;
`endif
      end
      ch_reset_q <= '0;
      expire_q   <= '0;
`ifdef WDT_ESCALATION_EN
      fault_q     <= '0;
      sys_reset_q <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
`ifdef WDT_ESCALATION_EN
        strikes_q[c] <= strikes_d[c];
`endif
      end
      ch_reset_q <= ch_reset_d;
      expire_q   <= expire_d;
`ifdef WDT_ESCALATION_EN
      fault_q     <= fault_d;
      sys_reset_q <= sys_reset_d;
`endif
    end
  end

  assign bus.o_ch_reset = ch_reset_q;
  assign bus.o_expire   = expire_q;
`ifdef WDT_ESCALATION_EN
  assign bus.o_fault     = fault_q;
  assign bus.o_sys_reset = sys_reset_q;
`else
  assign bus.o_fault     = '0;
  assign bus.o_sys_reset = 1'b0;
`endif

endmodule
